// File: rtl/ntt_pkg.sv
// Shared constants, types and twiddle table for the ML-KEM NTT engine.
// Modular helpers follow the Kyber reference arithmetic bit for bit.
package ntt_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int KYBER_N   = 256;
    localparam int QINV      = -3327;
    localparam int BARRETT_V = 20159;

    typedef logic signed [15:0] coef_t;

    localparam coef_t SCALE_F = 16'sd1441;
    localparam coef_t Q16     = 16'sd3329;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DONE
    } state_t;

    // Montgomery-form powers of 17 in bit-reversed order, centred representatives
    localparam int ZETAS [0:127] = '{
        -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
         -171,   622,  1577,   182,   962, -1202, -1474,  1468,
          573, -1325,   264,   383,  -829,  1458, -1602,  -130,
         -681,  1017,   732,   608, -1542,   411,  -205, -1571,
         1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
          516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
         -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
         -398,   961, -1508,  -725,   448, -1065,   677, -1275,
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    // Montgomery multiply: a*b*2^-16 mod q, |result| < q
    function automatic coef_t fqmul(coef_t a, coef_t b);
        logic signed [31:0] p;
        logic signed [31:0] m;
        coef_t              u;
        p = 32'(a) * 32'(b);
        m = p * QINV;
        u = m[15:0];
        m = p - 32'(u) * KYBER_Q;
        return m[31:16];
    endfunction

    // Centred Barrett reduction into [-(q-1)/2, (q-1)/2]
    function automatic coef_t barrett(coef_t a);
        logic signed [31:0] t;
        t = (32'(a) * BARRETT_V + 32'sd33554432) >>> 26;
        t = 32'(a) - t * KYBER_Q;
        return t[15:0];
    endfunction

    function automatic coef_t canon(coef_t a);
        coef_t r;
        r = barrett(a);
        return r[15] ? coef_t'(r + Q16) : r;
    endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// Combinational butterfly: Cooley-Tukey (forward) or Gentleman-Sande (inverse),
// with the 1441 scaling and canonical reduction applied on the final layer.
module ntt_butterfly
    import ntt_pkg::*;
(
    input  coef_t a,
    input  coef_t b,
    input  coef_t zeta,
    input  logic  inv,
    input  logic  last,
    output coef_t x_c,
    output coef_t y_c
);

    coef_t t;
    coef_t xs;
    coef_t ys;

    always_comb begin
        t  = fqmul(zeta, b);
        xs = a + t;
        ys = a - t;
        if (inv) begin
            xs = barrett(a + b);
            ys = fqmul(zeta, b - a);
            if (last) begin
                xs = fqmul(xs, SCALE_F);
                ys = fqmul(ys, SCALE_F);
            end
        end
        x_c = last ? canon(xs) : xs;
        y_c = last ? canon(ys) : ys;
    end

endmodule

// File: rtl/ntt.sv
// Serial-load, in-place NTT/INTT engine over 256 coefficients with one butterfly per cycle.
// The coefficient register file doubles as the parallel result output.
module ntt
    import ntt_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ready,
    input  logic              i_intt,
    input  coef_t             i_data,
    output logic              o_valid,
    output coef_t [0:7][0:31] o_data
);

    state_t      state;
    logic        inv;
    logic [7:0]  cnt;
    logic [6:0]  k;
    logic [7:0]  len;
    logic [7:0]  start;
    logic [7:0]  j;
    logic [7:0]  hi;
    logic [8:0]  blk_end;
    logic [8:0]  nstart;
    logic        blk_done;
    logic        last_layer;
    coef_t       x_c;
    coef_t       y_c;

    // Loop-nest bookkeeping mirroring the reference j/start/len iteration
    assign hi         = j + len;
    assign blk_end    = {1'b0, start} + {1'b0, len};
    assign nstart     = blk_end + {1'b0, len};
    assign blk_done   = ({1'b0, j} + 9'd1) == blk_end;
    assign last_layer = inv ? (len == 8'd128) : (len == 8'd2);

    ntt_butterfly u_bf (
        .a    (o_data[j[7:5]][j[4:0]]),
        .b    (o_data[hi[7:5]][hi[4:0]]),
        .zeta (16'(ZETAS[k])),
        .inv  (inv),
        .last (last_layer),
        .x_c  (x_c),
        .y_c  (y_c)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= ST_IDLE;
            inv     <= 1'b0;
            cnt     <= '0;
            k       <= '0;
            len     <= '0;
            start   <= '0;
            j       <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_ready) begin
                        inv          <= i_intt;
                        o_data[0][0] <= i_data;
                        o_valid      <= 1'b0;
                        cnt          <= 8'd1;
                        state        <= ST_LOAD;
                    end else if (state == ST_DONE) begin
                        o_valid <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (i_ready) begin
                        o_data[cnt[7:5]][cnt[4:0]] <= i_data;
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(KYBER_N - 1)) begin
                            state <= ST_COMPUTE;
                            j     <= '0;
                            start <= '0;
                            k     <= inv ? 7'd127 : 7'd1;
                            len   <= inv ? 8'd2 : 8'd128;
                        end
                    end
                end
                ST_COMPUTE: begin
                    o_data[j[7:5]][j[4:0]]   <= x_c;
                    o_data[hi[7:5]][hi[4:0]] <= y_c;
                    if (blk_done) begin
                        k <= inv ? k - 7'd1 : k + 7'd1;
                        if (nstart[8]) begin
                            start <= '0;
                            j     <= '0;
                            if (last_layer) begin
                                state <= ST_DONE;
                            end else begin
                                len <= inv ? len << 1 : len >> 1;
                            end
                        end else begin
                            start <= nstart[7:0];
                            j     <= nstart[7:0];
                        end
                    end else begin
                        j <= j + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt.sv
// Directed bench for the NTT engine: expected polynomials are queued at load time
// from an exact mod-q model and drained against o_data once o_valid rises.
module tb_ntt;

    localparam int Q    = 3329;
    localparam int RINV = 169;   // 2^-16 mod q
    localparam int LAT  = 897;

    logic                          clk = 1'b0;
    logic                          i_rst;
    logic                          i_ready;
    logic                          i_intt;
    logic signed [15:0]            i_data;
    logic                          o_valid;
    logic signed [0:7][0:31][15:0] o_data;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int stim[256];
    int mdl[256];
    int wz[128];

    ntt dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_ready (i_ready),
        .i_intt  (i_intt),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_data  (o_data)
    );

    always #5 clk = ~clk;

    function automatic int brv7(int x);
        int r = 0;
        for (int b = 0; b < 7; b++) r |= ((x >> b) & 1) << (6 - b);
        return r;
    endfunction

    function automatic int modq(int x);
        return ((x % Q) + Q) % Q;
    endfunction

    function automatic int coef(int i);
        return int'(o_data[i / 32][i % 32]);
    endfunction

    // Plain-domain transforms: Montgomery factors cancel, so only residues matter
    task automatic model_fwd();
        int k = 1;
        int t;
        int w;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int s = 0; s < 256; s += 2 * len) begin
                w = wz[k];
                k++;
                for (int jj = s; jj < s + len; jj++) begin
                    t = w * mdl[jj + len] % Q;
                    mdl[jj + len] = modq(mdl[jj] - t);
                    mdl[jj]       = (mdl[jj] + t) % Q;
                end
            end
        end
    endtask

    task automatic model_inv();
        int k  = 127;
        int sc = 1441 * RINV % Q;
        int t;
        int w;
        for (int len = 2; len <= 128; len = len * 2) begin
            for (int s = 0; s < 256; s += 2 * len) begin
                w = wz[k];
                k--;
                for (int jj = s; jj < s + len; jj++) begin
                    t = mdl[jj];
                    mdl[jj]       = (t + mdl[jj + len]) % Q;
                    mdl[jj + len] = w * modq(mdl[jj + len] - t) % Q;
                end
            end
        end
        for (int i = 0; i < 256; i++) mdl[i] = mdl[i] * sc % Q;
    endtask

    task automatic prep(input bit intt);
        for (int i = 0; i < 256; i++) mdl[i] = modq(stim[i]);
        if (intt) model_inv();
        else      model_fwd();
    endtask

    // Serial load; i_intt is flipped after the first beat to show it is sampled once
    task automatic load_poly(input bit intt, input bit gaps, input bit push);
        if (push) for (int i = 0; i < 256; i++) exp_q.push_back(mdl[i]);
        for (int i = 0; i < 256; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                    i_ready = 1'b0;
                    i_data  = 16'($urandom);
                    @(posedge clk); #1;
                end
            end
            i_ready = 1'b1;
            i_intt  = (i == 0) ? intt : ~intt;
            i_data  = 16'(stim[i]);
            @(posedge clk); #1;
            if (i == 0) begin
                total++;
                assert (o_valid === 1'b0) else begin
                    bad++;
                    $error("FAIL valid_fall: got %0b want 0", o_valid);
                end
            end
        end
        i_ready = 1'b0;
        i_intt  = 1'b0;
    endtask

    task automatic wait_done(input bit pulse, input string tag);
        int cyc = 0;
        int obs;
        int expv;
        while (!o_valid && cyc < 2000) begin
            if (pulse && cyc < 880) begin
                i_ready = 1'($urandom_range(0, 1));
                i_data  = 16'($urandom);
            end else begin
                i_ready = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_ready = 1'b0;
        total++;
        assert (cyc == LAT) else begin
            bad++;
            $error("FAIL %s_latency: got %0d want %0d", tag, cyc, LAT);
        end
        for (int i = 0; i < 256; i++) begin
            obs  = coef(i);
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            total++;
            assert (obs === expv) else begin
                bad++;
                $error("FAIL %s[%0d]: got %0d want %0d", tag, i, obs, expv);
            end
        end
    endtask

    initial begin
        int pw[128];
        int nmis;
        i_rst   = 1'b0;
        i_ready = 1'b0;
        i_intt  = 1'b0;
        i_data  = '0;
        pw[0] = 1;
        for (int i = 1; i < 128; i++) pw[i] = pw[i - 1] * 17 % Q;
        for (int k = 0; k < 128; k++) wz[k] = pw[brv7(k)];

        repeat (3) @(posedge clk); #1;
        total++;
        assert (o_valid === 1'b0) else begin
            bad++;
            $error("FAIL reset_valid: got %0b want 0", o_valid);
        end
        total++;
        assert (o_data === '0) else begin
            bad++;
            $error("FAIL reset_data: got nonzero want 0");
        end
        i_rst = 1'b1;
        @(posedge clk); #1;

        // all-zero forward
        for (int i = 0; i < 256; i++) stim[i] = 0;
        prep(1'b0);
        load_poly(1'b0, 1'b0, 1'b1);
        wait_done(1'b0, "zero");

        // impulse forward
        stim[0] = 1;
        prep(1'b0);
        load_poly(1'b0, 1'b0, 1'b1);
        wait_done(1'b0, "impulse");

        // ramp forward, then hold check
        for (int i = 0; i < 256; i++) stim[i] = i;
        prep(1'b0);
        load_poly(1'b0, 1'b0, 1'b1);
        wait_done(1'b0, "ramp");
        repeat (20) @(posedge clk);
        #1;
        nmis = 0;
        for (int i = 0; i < 256; i++) if (coef(i) != mdl[i]) nmis++;
        total++;
        assert (o_valid === 1'b1) else begin
            bad++;
            $error("FAIL hold_valid: got %0b want 1", o_valid);
        end
        total++;
        assert (nmis == 0) else begin
            bad++;
            $error("FAIL hold_data: got %0d changed coefficients want 0", nmis);
        end

        // round trip: inverse of the forward ramp result gives i*2^16 mod q
        for (int i = 0; i < 256; i++) stim[i] = mdl[i];
        for (int i = 0; i < 256; i++) mdl[i] = i * 2285 % Q;
        load_poly(1'b1, 1'b0, 1'b1);
        wait_done(1'b0, "roundtrip");

        // signed random inverse and forward
        for (int i = 0; i < 256; i++) stim[i] = int'($urandom_range(0, 2 * Q - 2)) - (Q - 1);
        prep(1'b1);
        load_poly(1'b1, 1'b0, 1'b1);
        wait_done(1'b0, "rand_inv");
        prep(1'b0);
        load_poly(1'b0, 1'b0, 1'b1);
        wait_done(1'b0, "rand_fwd");

        // ramp with load gaps and stray strobes during compute
        for (int i = 0; i < 256; i++) stim[i] = i;
        prep(1'b0);
        load_poly(1'b0, 1'b1, 1'b1);
        wait_done(1'b1, "ramp_gaps");

        // abort mid-compute
        load_poly(1'b0, 1'b0, 1'b0);
        repeat (300) @(posedge clk);
        #3;
        i_rst = 1'b0;
        #1;
        total++;
        assert (o_valid === 1'b0) else begin
            bad++;
            $error("FAIL abort_valid: got %0b want 0", o_valid);
        end
        total++;
        assert (o_data === '0) else begin
            bad++;
            $error("FAIL abort_data: got nonzero want 0");
        end
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;

        // clean run after abort
        prep(1'b0);
        load_poly(1'b0, 1'b0, 1'b1);
        wait_done(1'b0, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
